// File: rtl/buzzer_pkg.sv
// Shared types and sizing helpers for the buzzer pattern player.
package buzzer_pkg;

  // Player phases: waiting, sounding a symbol, silence after it, completion pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Symbol encoding inside Pattern.
  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  // Clocks per timing tick.
  function automatic int calc_cpt(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width shared by the prescaler, phase and tone-divider counters. Every
  // counter only ever reaches (its limit - 1), so $clog2 of the largest
  // limit is enough; never narrower than one bit.
  function automatic int cnt_width(input int cpt, input int dot, input int dash,
                                   input int gap, input int div);
    int m;
    int w;
    m = max2(max2(cpt, dot), max2(max2(dash, gap), div));
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/buzzer_tick_gen.sv
// Prescaler: one-clock tick every CPT clocks, restartable with a sync clear.
module buzzer_tick_gen #(
  parameter int CPT   = 10,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count 0..CPT-1; a clear restarts at 0 so the next tick is a full period away.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Tick depends on the register only, so clear never loops back into it.
  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/buzzer_pattern_player.sv
// Plays a dot/dash pattern of up to MAX_SYM symbols on a single buzzer pin.
//
// Handshake: Start_Sig is a request sampled only while IDLE (and only when
// Abort is low); the player then holds Busy high until the one-cycle
// Done_Sig pulse, which is itself a Busy cycle. Requests while Busy are dropped.
module buzzer_pattern_player
  import buzzer_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int MAX_SYM    = 8,
  parameter int DOT_MS     = 100,
  parameter int DASH_MS    = 400,
  parameter int GAP_MS     = 50,
  parameter int TONE_DIV   = 0,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                         CLK,
  input  logic                         RSTn,
  input  logic                         Start_Sig,
  input  logic [MAX_SYM-1:0]           Pattern,
  input  logic [$clog2(MAX_SYM+1)-1:0] Length,
  input  logic                         Abort,
  output logic                         Busy,
  output logic                         Done_Sig,
  output logic                         Pin_Out,
  output state_t                       dbg_state
);

  localparam int CPT   = calc_cpt(CLK_HZ, TICK_HZ);
  localparam int CNT_W = cnt_width(CPT, DOT_MS, DASH_MS, GAP_MS, TONE_DIV);
  localparam int LEN_W = $clog2(MAX_SYM + 1);
  localparam int IDX_W = (MAX_SYM > 1) ? $clog2(MAX_SYM) : 1;

  localparam logic [CNT_W-1:0] DOT_LAST  = CNT_W'(DOT_MS - 1);
  localparam logic [CNT_W-1:0] DASH_LAST = CNT_W'(DASH_MS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_MS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'((TONE_DIV > 0) ? TONE_DIV - 1 : 0);
  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_SYM);

  state_t             state_q;
  state_t             state_d;
  logic [MAX_SYM-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   phase_q;
  logic [CNT_W-1:0]   div_q;
  logic               tone_on_q;

  logic               tick;
  logic               phase_clear;
  logic               phase_end;
  logic               last_sym;
  logic [LEN_W-1:0]   len_clamped;
  logic [CNT_W-1:0]   phase_last;
  logic               sounding;

  // Every state entry restarts the prescaler so each phase gets whole ticks.
  buzzer_tick_gen #(
    .CPT   (CPT),
    .CNT_W (CNT_W)
  ) u_tick_gen (
    .clk   (CLK),
    .rstn  (RSTn),
    .clear (phase_clear),
    .tick  (tick)
  );

  // Phase-length selection and end-of-phase / end-of-pattern detection.
  always_comb begin
    len_clamped = (Length > MAX_LEN) ? MAX_LEN : Length;
    phase_last  = GAP_LAST;
    if (state_q == TONE) begin
      phase_last = (pattern_q[idx_q] == SYM_DASH) ? DASH_LAST : DOT_LAST;
    end
    phase_end = tick && (phase_q == phase_last);
    last_sym  = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
  end

  // Next-state logic; Abort overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    if ((state_q != IDLE) && Abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start_Sig && !Abort) begin
            state_d = (len_clamped != '0) ? TONE : DONE;
          end
        end
        TONE: begin
          if (phase_end) state_d = GAP;
        end
        GAP: begin
          if (phase_end) state_d = last_sym ? DONE : TONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    phase_clear = (state_d != state_q) || (state_q == IDLE);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pattern capture, symbol index and phase tick counter.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      pattern_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      phase_q   <= '0;
    end else begin
      if ((state_q == IDLE) && (state_d != IDLE)) begin
        pattern_q <= Pattern;
        len_q     <= len_clamped;
        idx_q     <= '0;
      end else if ((state_q == GAP) && (state_d == TONE)) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (phase_clear) begin
        phase_q <= '0;
      end else if (tick) begin
        phase_q <= phase_q + CNT_W'(1);
      end
    end
  end

  // Tone shaping: starts sounding on TONE entry, optionally toggles every TONE_DIV clocks.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      div_q     <= '0;
      tone_on_q <= 1'b0;
    end else if ((state_d == TONE) && (state_q != TONE)) begin
      div_q     <= '0;
      tone_on_q <= 1'b1;
    end else if ((state_q == TONE) && (TONE_DIV > 0)) begin
      if (div_q == DIV_LAST) begin
        div_q     <= '0;
        tone_on_q <= ~tone_on_q;
      end else begin
        div_q <= div_q + CNT_W'(1);
      end
    end
  end

  assign sounding  = (state_q == TONE) && tone_on_q;
  assign Pin_Out   = (ACTIVE_LOW != 0) ? ~sounding : sounding;
  assign Busy      = (state_q != IDLE);
  assign Done_Sig  = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_buzzer_pattern_player.sv
// Directed bench for buzzer_pattern_player: a DC-tone instance and a TONE_DIV=2 instance.
module tb_buzzer_pattern_player;
  import buzzer_pkg::*;

  localparam int CPT  = 10;
  localparam int DOT  = 2 * CPT;
  localparam int DASH = 6 * CPT;
  localparam int GAP  = 1 * CPT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn    = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] length  = '0;
  logic       abort   = 1'b0;

  logic   busy_a, done_a, pin_a;
  logic   busy_b, done_b, pin_b;
  state_t st_a, st_b;

  buzzer_pattern_player #(
    .CLK_HZ(10_000), .TICK_HZ(1000), .MAX_SYM(8), .DOT_MS(2), .DASH_MS(6),
    .GAP_MS(1), .TONE_DIV(0), .ACTIVE_LOW(1)
  ) dut_a (
    .CLK(clk), .RSTn(rstn), .Start_Sig(start_a), .Pattern(pattern), .Length(length),
    .Abort(abort), .Busy(busy_a), .Done_Sig(done_a), .Pin_Out(pin_a), .dbg_state(st_a)
  );

  buzzer_pattern_player #(
    .CLK_HZ(10_000), .TICK_HZ(1000), .MAX_SYM(8), .DOT_MS(2), .DASH_MS(6),
    .GAP_MS(1), .TONE_DIV(2), .ACTIVE_LOW(1)
  ) dut_b (
    .CLK(clk), .RSTn(rstn), .Start_Sig(start_b), .Pattern(pattern), .Length(length),
    .Abort(abort), .Busy(busy_b), .Done_Sig(done_b), .Pin_Out(pin_b), .dbg_state(st_b)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Move to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected pin per cycle after the Start edge, up to (not including) DONE.
  task automatic build_wave(input logic [7:0] pat, input int len, input int div);
    int l;
    int d;
    exp_q.delete();
    l = (len > 8) ? 8 : len;
    for (int s = 0; s < l; s++) begin
      d = pat[s] ? DASH : DOT;
      for (int c = 0; c < d; c++) begin
        if (div == 0) exp_q.push_back(1'b0);
        else          exp_q.push_back(((c / div) % 2) ? 1'b1 : 1'b0);
      end
      for (int c = 0; c < GAP; c++) exp_q.push_back(1'b1);
    end
  endtask

  // ---------------- driver for one table vector ----------------
  typedef struct {
    string      name;
    bit         sel;
    logic [7:0] pattern;
    logic [3:0] length;
    int         div;
    int         inj_at;
    int         exp_done;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    int   first_done = -1;
    int   done_cnt   = 0;
    int   wave_err   = 0;
    int   busy_done  = 0;
    int   busy_after = 1;
    logic pin, busy, done, exp_pin;
    build_wave(v.pattern, int'(v.length), v.div);
    pattern = v.pattern;
    length  = v.length;
    if (v.sel) start_b = 1'b1; else start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    for (int o = 1; o <= v.exp_done + 3; o++) begin
      pin  = v.sel ? pin_b  : pin_a;
      busy = v.sel ? busy_b : busy_a;
      done = v.sel ? done_b : done_a;
      exp_pin = (o <= exp_q.size()) ? exp_q[o-1] : 1'b1;
      if (pin !== exp_pin) wave_err++;
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = o;
      end
      if (o == v.exp_done) busy_done = int'(busy);
      if (o == v.exp_done + 1) busy_after = int'(busy);
      if (v.inj_at != 0 && o == v.inj_at) begin
        pattern = 8'hFF;
        length  = 4'd2;
        if (v.sel) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      step();
    end
    start_a = 1'b0;
    start_b = 1'b0;
    check({v.name, " done_cycle"}, first_done, v.exp_done);
    check({v.name, " done_pulses"}, done_cnt, 1);
    check({v.name, " pin_wave_errs"}, wave_err, 0);
    check({v.name, " busy_at_done"}, busy_done, 1);
    check({v.name, " busy_after_done"}, busy_after, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lows;
    int dones;

    vecs[0] = '{"S",        1'b0, 8'h00, 4'd3,  0, 0, 91};
    vecs[1] = '{"O",        1'b0, 8'h07, 4'd3,  0, 0, 211};
    vecs[2] = '{"mixed",    1'b0, 8'h02, 4'd2,  0, 0, 101};
    vecs[3] = '{"len0",     1'b0, 8'h00, 4'd0,  0, 0, 1};
    vecs[4] = '{"dash1",    1'b0, 8'h01, 4'd1,  0, 0, 71};
    vecs[5] = '{"clamp15",  1'b0, 8'hA5, 4'd15, 0, 0, 401};
    vecs[6] = '{"S_inject", 1'b0, 8'h00, 4'd3,  0, 5, 91};
    vecs[7] = '{"div2_dot", 1'b1, 8'h00, 4'd1,  2, 0, 31};

    // Reset held with Start asserted: player stays silent and idle.
    rstn    = 1'b0;
    start_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_pin", int'(pin_a), 1);
      check("reset_busy", int'(busy_a), 0);
      check("reset_done", int'(done_a), 0);
    end
    check("reset_state", int'(st_a), int'(IDLE));
    start_a = 1'b0;
    rstn    = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("post_reset_busy", int'(busy_a), 0);
    check("post_reset_pin", int'(pin_a), 1);

    // Table vectors.
    foreach (vecs[i]) begin
      run_vec(vecs[i]);
      step();
    end

    // Abort mid-"S": silent and idle one edge later, no Done pulse.
    pattern = 8'h00;
    length  = 4'd3;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int o = 1; o < 15; o++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_pin", int'(pin_a), 1);
    check("abort_busy", int'(busy_a), 0);
    lows  = 0;
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      if (pin_a === 1'b0) lows++;
      if (done_a === 1'b1) dones++;
      step();
    end
    check("abort_no_done", dones, 0);
    check("abort_no_tone", lows, 0);
    run_vec(vecs[0]);

    // Abort and Start together while IDLE: Start is dropped.
    abort   = 1'b1;
    start_a = 1'b1;
    step();
    abort   = 1'b0;
    start_a = 1'b0;
    check("abort_start_busy", int'(busy_a), 0);
    check("abort_start_pin", int'(pin_a), 1);
    step();
    check("abort_start_state", int'(st_a), int'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global bound on simulated time.
  initial begin
    #200_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/buzzer_pattern_player.md
Name: buzzer_pattern_player

Overview:
Parametrised successor to the fixed "S"/"O" beeper. Plays a programmable dot/dash sequence of up to MAX_SYM symbols on one buzzer pin. Symbol and gap timing are derived from a millisecond tick. Tone output is either DC or a square wave. Sits between the top-level sequencer, which issues Start_Sig and waits for Done_Sig, and the buzzer pad.

Parameters:
CLK_HZ, 50_000_000, input clock frequency.
TICK_HZ, 1000, timing tick rate. Clocks per tick CPT = CLK_HZ/TICK_HZ; must be an integer ≥2.
MAX_SYM, 8, maximum symbols per pattern.
DOT_MS, 100, dot tone duration in ticks.
DASH_MS, 400, dash tone duration in ticks.
GAP_MS, 50, silence after every symbol, in ticks.
TONE_DIV, 0, 0 = DC tone; N>0 = square wave toggling every N clocks.
ACTIVE_LOW, 1, 1 = Pin_Out low means sounding.

Ports:
CLK  in  1  system clock
RSTn  in  1  reset (see below)
Start_Sig  in  1  start request, sampled only in IDLE
Pattern  in  MAX_SYM  symbol i = Pattern[i]; 0 = dot, 1 = dash; bit 0 played first
Length  in  $clog2(MAX_SYM+1)  number of symbols; values above MAX_SYM clamp to MAX_SYM
Abort  in  1  stop immediately
Busy  out  1  high in TONE, GAP, DONE
Done_Sig  out  1  one-cycle completion pulse
Pin_Out  out  1  buzzer drive

Behaviour:
- Clock and reset (already decided): one clock, CLK; reset RSTn is synchronous and active-low.
- Reset values: state IDLE, Busy=0, Done_Sig=0, Pin_Out inactive (=ACTIVE_LOW), all counters 0.
- Start in IDLE:
  - Start_Sig=1 latches Pattern and clamped Length, and sets index=0.
  - If Length≠0, enter TONE on the next edge. Pin_Out is active in the cycle after Start is sampled (latency 1).
  - If Length=0, go to DONE directly; no tone is produced.
- TONE:
  - Duration is (Pattern[index] ? DASH_MS : DOT_MS)·CPT clocks exactly.
  - Then enter GAP with the pin inactive.
- GAP:
  - Duration is GAP_MS·CPT clocks.
  - If index==Length−1, go to DONE; otherwise index++ and go to TONE.
  - The gap follows every symbol, including the last one.
- DONE: lasts 1 cycle with Done_Sig=1 and Busy=1, then IDLE.
- Total cycles from Start sample to the Done cycle = 1 + Σ(tone clocks) + Length·GAP_MS·CPT.
- Tick generator: cleared on every state entry, so each phase starts with a full tick. The tick counter wraps at CPT−1, and the phase counter compares against duration−1 on a tick.
- Tone shaping:
  - TONE_DIV=0: Pin_Out is constantly active in TONE.
  - TONE_DIV>0: Pin_Out starts active on TONE entry and toggles every TONE_DIV clocks. The divider resets on each TONE entry.
  - Pin_Out is inactive in IDLE, GAP and DONE.
- Start_Sig while Busy: ignored; latched pattern unchanged.
- Abort:
  - Highest priority, below reset.
  - In any non-IDLE state, go to IDLE next edge with the pin inactive and no Done_Sig.
  - Abort and Start in the same IDLE cycle: Start is ignored.
- Pattern/Length changes while Busy have no effect.
- Counter widths are sized by $clog2 of max(CPT, DASH_MS, GAP_MS, DOT_MS, TONE_DIV); no overflow is allowed.

Decomposition:
- Package buzzer_pkg holds:
  - state enum {IDLE, TONE, GAP, DONE}
  - SYM_DOT/SYM_DASH codes
  - function computing CPT and counter widths
- Sub-module buzzer_tick_gen: prescaler with sync clear input; outputs a one-clock tick every CPT clocks.

Test Plan:
All tests use CLK_HZ=10_000, TICK_HZ=1000 (CPT=10), DOT_MS=2, DASH_MS=6, GAP_MS=1, ACTIVE_LOW=1 unless stated. Start is sampled at cycle k.
1. Hold RSTn=0 for 3 cycles while Start_Sig=1 → Pin_Out=1, Busy=0, Done_Sig=0 throughout. Release: still IDLE until a Start is sampled.
2. "S" (Pattern=0, Length=3) → three 20-clock lows, each followed by a 10-clock high. Done_Sig=1 only at cycle k+91; Busy low at k+92.
3. "O" (Pattern=3'b111, Length=3) → three 60-clock lows with 10-clock gaps. Done at k+211. Mixed Pattern=2'b10, Length=2 → 20-clock low, then 60-clock low; Done at k+101.
4. Assert Abort at k+15 during "S" → Pin_Out=1 and Busy=0 from k+16, no Done pulse. A new Start then plays in full.
5. Length=0 → Done at k+1, no low on Pin_Out. Start pulse at k+5 during "S" → ignored; Done still at k+91. Length=15 with MAX_SYM=8 → plays 8 symbols.
6. TONE_DIV=2, dot → Pin_Out pattern 0,0,1,1,… for 20 clocks starting low, then 1 throughout GAP.
